cpu_controller: RTL and testbench

Control FSM and instruction register that drives the 16-bit register-file/ALU datapath. It latches one instruction, decodes it and sequences the datapath's per-cycle control strobes: register read/write numbers, A/B/C/status loads, mux selects, shift and ALU op. It reports idle through w so a top-level tester or the memory stage can issue the next instruction.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/cpu_controller_instr_dec.sv | 28 ++
 rtl/cpu_controller.sv | 147 ++++++++++++++
 tb/tb_cpu_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction controller: field layout, opcodes, FSM states and the control-strobe bundle.
package cpu_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OPC_W  = 3;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned REG_W  = 3;
   localparam int unsigned SH_W   = 2;
   localparam int unsigned IMM_W  = 8;
   localparam int unsigned ALU_W  = 2;

   // Bit positions of the instruction fields
   localparam int unsigned OPC_LSB = 13;
   localparam int unsigned OP_LSB  = 11;
   localparam int unsigned RN_LSB  = 8;
   localparam int unsigned RD_LSB  = 5;
   localparam int unsigned SH_LSB  = 3;
   localparam int unsigned RM_LSB  = 0;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
   localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

   localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
   localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
   localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
   localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

   localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_COMPUTE,
      S_WRITE_REG
   } state_t;

   // Per-cycle datapath control strobes
   typedef struct packed {
      logic             w;
      logic [REG_W-1:0] readnum;
      logic [REG_W-1:0] writenum;
      logic             write;
      logic             vsel;
      logic             loada;
      logic             loadb;
      logic             loadc;
      logic             loads;
      logic             asel;
      logic [SH_W-1:0]  shift;
      logic [ALU_W-1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{w: 1'b1, readnum: '0, writenum: '0, write: 1'b0,
                                   vsel: 1'b0, loada: 1'b0, loadb: 1'b0, loadc: 1'b0,
                                   loads: 1'b0, asel: 1'b0, shift: '0, aluop: '0};

   // Sign-extend the 8-bit immediate to datapath width
   function automatic logic [DATA_W-1:0] sign_ext_imm8(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Combinational instruction-register field extraction, immediate sign extension and legality check.
module instr_dec
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] ir,
   output logic [OPC_W-1:0]  opcode,
   output logic [OP_W-1:0]   op,
   output logic [REG_W-1:0]  rn,
   output logic [REG_W-1:0]  rd,
   output logic [SH_W-1:0]   sh,
   output logic [REG_W-1:0]  rm,
   output logic [DATA_W-1:0] sximm8,
   output logic              supported
);

   assign opcode = ir[OPC_LSB +: OPC_W];
   assign op     = ir[OP_LSB  +: OP_W];
   assign rn     = ir[RN_LSB  +: REG_W];
   assign rd     = ir[RD_LSB  +: REG_W];
   assign sh     = ir[SH_LSB  +: SH_W];
   assign rm     = ir[RM_LSB  +: REG_W];
   assign sximm8 = sign_ext_imm8(ir[IMM_LSB +: IMM_W]);

   // MOV immediate, MOV register and all four ALU ops are executable; everything else is dropped
   assign supported = ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)))
                    || (opcode == OPC_ALU);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus control FSM sequencing the register-file/ALU datapath strobes.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in,
   input  logic              load,
   input  logic              s,
   output logic              w,
   output logic [REG_W-1:0]  readnum,
   output logic [REG_W-1:0]  writenum,
   output logic              write,
   output logic              vsel,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [SH_W-1:0]   shift,
   output logic [ALU_W-1:0]  ALUop,
   output logic [DATA_W-1:0] datapath_in
);

   logic [DATA_W-1:0] ir;
   state_t            state, state_n;
   ctrl_t             ctrl, ctrl_n;

   logic [OPC_W-1:0]  opcode;
   logic [OP_W-1:0]   op;
   logic [REG_W-1:0]  rn, rd, rm;
   logic [SH_W-1:0]   sh;
   logic [DATA_W-1:0] sximm8;
   logic              supported;

   logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

   instr_dec u_dec (
      .ir        (ir),
      .opcode    (opcode),
      .op        (op),
      .rn        (rn),
      .rd        (rd),
      .sh        (sh),
      .rm        (rm),
      .sximm8    (sximm8),
      .supported (supported)
   );

   assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign is_alu     = (opcode == OPC_ALU);
   assign is_cmp     = is_alu && (op == OP_CMP);
   assign is_mvn     = is_alu && (op == OP_MVN);

   // State and instruction register; IR only accepts a new word while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         state <= state_n;
         if ((state == S_WAIT) && load) begin
            ir <= in;
         end
      end
   end

   // Next-state sequencing per instruction class
   always_comb begin
      state_n = state;
      case (state)
         S_WAIT:      if (s) state_n = S_DECODE;
         S_DECODE: begin
            if (!supported)                      state_n = S_WAIT;
            else if (is_mov_imm)                 state_n = S_WRITE_IMM;
            else if (is_alu && !is_mvn)          state_n = S_GET_A;
            else                                 state_n = S_GET_B;
         end
         S_WRITE_IMM: state_n = S_WAIT;
         S_GET_A:     state_n = S_GET_B;
         S_GET_B:     state_n = S_COMPUTE;
         S_COMPUTE:   state_n = is_cmp ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_n = S_WAIT;
         default:     state_n = S_WAIT;
      endcase
   end

   // Strobes for the state being entered; IR fields are stable in every state that uses them
   always_comb begin
      ctrl_n = '0;
      case (state_n)
         S_WAIT: ctrl_n.w = 1'b1;
         S_WRITE_IMM: begin
            ctrl_n.write    = 1'b1;
            ctrl_n.vsel     = 1'b1;
            ctrl_n.writenum = rn;
         end
         S_GET_A: begin
            ctrl_n.readnum = rn;
            ctrl_n.loada   = 1'b1;
         end
         S_GET_B: begin
            ctrl_n.readnum = rm;
            ctrl_n.loadb   = 1'b1;
         end
         S_COMPUTE: begin
            ctrl_n.shift = sh;
            ctrl_n.asel  = is_mov_reg || is_mvn;
            ctrl_n.aluop = is_alu ? ALU_W'(op) : ALU_ADD;
            ctrl_n.loads = is_cmp;
            ctrl_n.loadc = !is_cmp;
         end
         S_WRITE_REG: begin
            ctrl_n.write    = 1'b1;
            ctrl_n.writenum = rd;
         end
         default: ctrl_n = '0;
      endcase
   end

   // Registered control outputs, idle on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl <= CTRL_IDLE;
      end else begin
         ctrl <= ctrl_n;
      end
   end

   assign w           = ctrl.w;
   assign readnum     = ctrl.readnum;
   assign writenum    = ctrl.writenum;
   assign write       = ctrl.write;
   assign vsel        = ctrl.vsel;
   assign loada       = ctrl.loada;
   assign loadb       = ctrl.loadb;
   assign loadc       = ctrl.loadc;
   assign loads       = ctrl.loads;
   assign asel        = ctrl.asel;
   assign bsel        = 1'b0;
   assign shift       = ctrl.shift;
   assign ALUop       = ctrl.aluop;
   assign datapath_in = sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed scenarios plus random programs checked against an ISA-level model.
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in = 16'h0;
   logic        load = 1'b0;
   logic        s = 1'b0;
   logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;

   always #5 clk = ~clk;

   cpu_controller dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
      .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;

   // Architectural state predicted from instruction semantics
   logic [15:0] arch_r [8] = '{default: 16'h0};
   logic        arch_z = 1'b0;

   // Datapath driven by the controller's strobes
   logic [15:0] dp_r [8] = '{default: 16'h0};
   logic [15:0] dp_a = 16'h0, dp_b = 16'h0, dp_c = 16'h0;
   logic        dp_z = 1'b0;

   function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
      case (sh)
         2'b00:   return v;
         2'b01:   return {v[14:0], 1'b0};
         2'b10:   return {1'b0, v[15:1]};
         default: return {v[15], v[15:1]};
      endcase
   endfunction

   function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return ~b;
      endcase
   endfunction

   // Register file, A/B/C and Z registers reacting to the strobes of each cycle
   always @(posedge clk) begin
      if (write === 1'b1) begin
         dp_r[writenum] <= (vsel === 1'b1) ? datapath_in : dp_c;
         wr_count <= wr_count + 1;
      end
      if (loada === 1'b1) dp_a <= dp_r[readnum];
      if (loadb === 1'b1) dp_b <= dp_r[readnum];
      if (loadc === 1'b1)
         dp_c <= alu_f(ALUop, (asel === 1'b1) ? 16'h0 : dp_a,
                       (bsel === 1'b1) ? 16'(datapath_in[4:0]) : shf(dp_b, shift));
      if (loads === 1'b1)
         dp_z <= (alu_f(ALUop, (asel === 1'b1) ? 16'h0 : dp_a,
                        (bsel === 1'b1) ? 16'(datapath_in[4:0]) : shf(dp_b, shift)) == 16'h0);
   end

   // ISA semantics
   task automatic arch_apply(input logic [15:0] i);
      logic [2:0]  opc, rn, rd, rm;
      logic [1:0]  op, sh;
      logic [15:0] bv;
      opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
      bv  = shf(arch_r[rm], sh);
      if (opc == 3'b110 && op == 2'b10)      arch_r[rn] = {{8{i[7]}}, i[7:0]};
      else if (opc == 3'b110 && op == 2'b00) arch_r[rd] = bv;
      else if (opc == 3'b101) begin
         case (op)
            2'b00:   arch_r[rd] = arch_r[rn] + bv;
            2'b01:   arch_z = ((arch_r[rn] - bv) == 16'h0);
            2'b10:   arch_r[rd] = arch_r[rn] & bv;
            default: arch_r[rd] = ~bv;
         endcase
      end
   endtask

   function automatic int exp_lat(input logic [15:0] i);
      if (i[15:13] == 3'b110 && i[12:11] == 2'b10) return 2;
      if (i[15:13] == 3'b110 && i[12:11] == 2'b00) return 4;
      if (i[15:13] == 3'b101) return (i[12:11] == 2'b00 || i[12:11] == 2'b10) ? 5 : 4;
      return 1;
   endfunction

   function automatic int exp_wr(input logic [15:0] i);
      if (i[15:13] == 3'b110 && (i[12:11] == 2'b10 || i[12:11] == 2'b00)) return 1;
      if (i[15:13] == 3'b101 && i[12:11] != 2'b01) return 1;
      return 0;
   endfunction

   function automatic logic [15:0] gen_instr();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 7))
         0, 1, 2: x[15:11] = 5'b11010;
         3:       x[15:11] = 5'b11000;
         4, 5, 6: x[15:13] = 3'b101;
         default: ;
      endcase
      return x;
   endfunction

   // Load and start an instruction; returns at the falling edge after the start edge
   task automatic start(input logic [15:0] i);
      @(negedge clk); in = i; load = 1'b1; s = 1'b1;
      @(negedge clk); load = 1'b0; s = 1'b0;
   endtask

   // Run an instruction to completion, measuring cycles from the start edge to w=1
   task automatic issue(input logic [15:0] i, output int lat);
      start(i);
      lat = 0;
      while (w !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL reset_w: got %b want 1", w); end
      n_checks++; if ({write, vsel, loada, loadb, loadc, loads, asel, bsel} !== 8'h0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {write, vsel, loada, loadb, loadc, loads, asel, bsel}); end
      n_checks++; if ({readnum, writenum, shift, ALUop} !== 10'h0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {readnum, writenum, shift, ALUop}); end
      n_checks++; if (datapath_in !== 16'h0) begin n_fail++; $display("FAIL reset_dpin: got %h want 0000", datapath_in); end
      reset = 1'b0;
   endtask

   task automatic test_mov_imm();
      arch_apply(16'hD007);
      start(16'hD007);
      n_checks++; if (w !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL movi_decode: w=%b write=%b want 0 0", w, write); end
      @(negedge clk);
      n_checks++; if ({write, vsel, writenum} !== {1'b1, 1'b1, 3'd0}) begin n_fail++; $display("FAIL movi_write: write=%b vsel=%b wn=%0d want 1 1 0", write, vsel, writenum); end
      n_checks++; if (datapath_in !== 16'h0007) begin n_fail++; $display("FAIL movi_imm: got %h want 0007", datapath_in); end
      @(negedge clk);
      n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL movi_latency: w=%b want 1", w); end
      arch_apply(16'hD4FF);
      start(16'hD4FF);
      @(negedge clk);
      n_checks++; if (datapath_in !== 16'hFFFF || writenum !== 3'd4) begin n_fail++; $display("FAIL movi_neg: dpin=%h wn=%0d want ffff 4", datapath_in, writenum); end
      @(negedge clk);
      n_checks++; if (dp_r[4] !== 16'hFFFF) begin n_fail++; $display("FAIL movi_r4: got %h want ffff", dp_r[4]); end
   endtask

   task automatic test_add();
      int lat;
      arch_apply(16'hD007); issue(16'hD007, lat);
      arch_apply(16'hD102); issue(16'hD102, lat);
      arch_apply(16'hA148);
      start(16'hA148);
      @(negedge clk);
      n_checks++; if (readnum !== 3'd1 || loada !== 1'b1) begin n_fail++; $display("FAIL add_geta: rn=%0d loada=%b want 1 1", readnum, loada); end
      @(negedge clk);
      n_checks++; if (readnum !== 3'd0 || loadb !== 1'b1) begin n_fail++; $display("FAIL add_getb: rn=%0d loadb=%b want 0 1", readnum, loadb); end
      @(negedge clk);
      n_checks++; if ({shift, ALUop, asel, loadc, loads} !== 7'b01_00_0_1_0) begin n_fail++; $display("FAIL add_compute: got %b want 0100010", {shift, ALUop, asel, loadc, loads}); end
      @(negedge clk);
      n_checks++; if ({write, vsel, writenum} !== {1'b1, 1'b0, 3'd2}) begin n_fail++; $display("FAIL add_wb: write=%b vsel=%b wn=%0d want 1 0 2", write, vsel, writenum); end
      @(negedge clk);
      n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL add_latency: w=%b want 1", w); end
      n_checks++; if (dp_r[2] !== 16'd16) begin n_fail++; $display("FAIL add_r2: got %0d want 16", dp_r[2]); end
   endtask

   task automatic test_cmp();
      int w0;
      w0 = wr_count;
      arch_apply(16'hA800);
      start(16'hA800);
      @(negedge clk); @(negedge clk); @(negedge clk);
      n_checks++; if ({loads, loadc, ALUop} !== 4'b1_0_01) begin n_fail++; $display("FAIL cmp_compute: got %b want 1001", {loads, loadc, ALUop}); end
      @(negedge clk);
      n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL cmp_latency: w=%b want 1", w); end
      n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL cmp_nowrite: got %0d writes want 0", wr_count - w0); end
      n_checks++; if (dp_z !== 1'b1) begin n_fail++; $display("FAIL cmp_z: got %b want 1", dp_z); end
   endtask

   task automatic test_mvn();
      arch_apply(16'hB861);
      start(16'hB861);
      @(negedge clk);
      n_checks++; if (loada !== 1'b0 || loadb !== 1'b1 || readnum !== 3'd1) begin n_fail++; $display("FAIL mvn_getb: loada=%b loadb=%b rn=%0d want 0 1 1", loada, loadb, readnum); end
      @(negedge clk);
      n_checks++; if (asel !== 1'b1 || ALUop !== 2'b11) begin n_fail++; $display("FAIL mvn_compute: asel=%b aluop=%b want 1 11", asel, ALUop); end
      @(negedge clk);
      n_checks++; if (write !== 1'b1 || writenum !== 3'd3) begin n_fail++; $display("FAIL mvn_wb: write=%b wn=%0d want 1 3", write, writenum); end
      @(negedge clk);
      n_checks++; if (w !== 1'b1 || dp_r[3] !== 16'hFFFD) begin n_fail++; $display("FAIL mvn_r3: w=%b r3=%h want 1 fffd", w, dp_r[3]); end
   endtask

   task automatic test_unsupported();
      int w0;
      w0 = wr_count;
      start(16'hE000);
      n_checks++; if ({w, write, loada, loadb, loadc, loads} !== 6'h0) begin n_fail++; $display("FAIL unsup_decode: got %b want 0", {w, write, loada, loadb, loadc, loads}); end
      @(negedge clk);
      n_checks++; if (w !== 1'b1 || wr_count != w0) begin n_fail++; $display("FAIL unsup_wait: w=%b writes=%0d want 1 0", w, wr_count - w0); end
   endtask

   task automatic test_load_ignored();
      arch_apply(16'hB861);
      start(16'hB861);
      @(negedge clk); in = 16'hD7AA; load = 1'b1;
      @(negedge clk); load = 1'b0;
      n_checks++; if (datapath_in !== 16'h0061) begin n_fail++; $display("FAIL busy_load: dpin=%h want 0061", datapath_in); end
      @(negedge clk); @(negedge clk);
      n_checks++; if (w !== 1'b1 || dp_r[7] !== arch_r[7] || dp_r[3] !== 16'hFFFD) begin n_fail++; $display("FAIL busy_load_regs: w=%b r7=%h r3=%h want 1 %h fffd", w, dp_r[7], dp_r[3], arch_r[7]); end
   endtask

   task automatic test_reset_mid();
      int w0;
      start(16'hA148);
      @(negedge clk); @(negedge clk); @(negedge clk);
      n_checks++; if (loadc !== 1'b1 || datapath_in !== 16'h0048) begin n_fail++; $display("FAIL rstmid_compute: loadc=%b dpin=%h want 1 0048", loadc, datapath_in); end
      w0 = wr_count;
      reset = 1'b1;
      #1;
      n_checks++; if (w !== 1'b1 || loadc !== 1'b0 || datapath_in !== 16'h0) begin n_fail++; $display("FAIL rstmid_async: w=%b loadc=%b dpin=%h want 1 0 0000", w, loadc, datapath_in); end
      @(negedge clk); reset = 1'b0;
      @(negedge clk); @(negedge clk);
      n_checks++; if (wr_count != w0 || w !== 1'b1 || datapath_in !== 16'h0) begin n_fail++; $display("FAIL rstmid_after: writes=%0d w=%b dpin=%h want 0 1 0000", wr_count - w0, w, datapath_in); end
   endtask

   task automatic test_back_to_back();
      int w0;
      w0 = wr_count;
      arch_apply(16'hD007);
      @(negedge clk); in = 16'hD007; load = 1'b1; s = 1'b1;
      @(negedge clk); load = 1'b0;
      @(negedge clk); @(negedge clk);
      n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: w=%b want 1", w); end
      @(negedge clk); s = 1'b0;
      n_checks++; if (w !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: w=%b want 0", w); end
      @(negedge clk); @(negedge clk);
      n_checks++; if (w !== 1'b1 || wr_count - w0 != 2) begin n_fail++; $display("FAIL b2b_done: w=%b writes=%0d want 1 2", w, wr_count - w0); end
   endtask

   task automatic test_random();
      logic [15:0] i;
      int lat, w0;
      logic same;
      for (int k = 0; k < 40; k++) begin
         i  = gen_instr();
         w0 = wr_count;
         arch_apply(i);
         issue(i, lat);
         n_checks++; if (lat != exp_lat(i)) begin n_fail++; $display("FAIL rnd_latency %h: got %0d want %0d", i, lat, exp_lat(i)); end
         n_checks++; if (wr_count - w0 != exp_wr(i)) begin n_fail++; $display("FAIL rnd_writes %h: got %0d want %0d", i, wr_count - w0, exp_wr(i)); end
         same = 1'b1;
         for (int r = 0; r < 8; r++) if (dp_r[r] !== arch_r[r]) same = 1'b0;
         n_checks++; if (!same) begin n_fail++; $display("FAIL rnd_regs %h: got %h %h %h %h %h %h %h %h want %h %h %h %h %h %h %h %h", i, dp_r[0], dp_r[1], dp_r[2], dp_r[3], dp_r[4], dp_r[5], dp_r[6], dp_r[7], arch_r[0], arch_r[1], arch_r[2], arch_r[3], arch_r[4], arch_r[5], arch_r[6], arch_r[7]); end
         n_checks++; if (dp_z !== arch_z) begin n_fail++; $display("FAIL rnd_z %h: got %b want %b", i, dp_z, arch_z); end
      end
   endtask

   initial begin
      test_reset();
      test_mov_imm();
      test_add();
      test_cmp();
      test_mvn();
      test_unsupported();
      test_load_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
